// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state encoding and header byte base for uart_tx_arbiter
package uart_arb_pkg;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [7:0] HDR_BASE  = 8'hA0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, search starts just above last_grant_i
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_grant_i,
  output logic [IDW-1:0]  winner_o,
  output logic            any_req_o
);
  logic [IDW-1:0] idx;
  // walk from farthest to nearest so the closest requester above last_grant wins
  always_comb begin
    winner_o = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(last_grant_i) + 1 + k) % NREQ);
      winner_o = req_i[idx] ? idx : winner_o;
    end
  end
  assign any_req_o = |req_i;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, words sent LSB byte first.
// Define UART_TX_ARB_HEADER_EN to prefix each word with header byte 8'hA0 | grant_id.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*8*NBYTES-1:0] req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     grant_valid,
  output logic [IDW-1:0]           grant_id,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy
);
  localparam int W  = 8 * NBYTES;
  localparam int BW = NBYTES > 1 ? $clog2(NBYTES) : 1;
`ifdef UART_TX_ARB_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  logic [2:0]     state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [BW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic           hdr_q, hdr_d;
  logic [IDW-1:0] winner;
  logic           any_req;
  logic [W-1:0]   win_word;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .any_req_o    (any_req)
  );

  always_comb begin
    win_word = '0;
    for (int k = 0; k < NREQ; k++)
      win_word = (winner == IDW'(k)) ? req_data[k*W +: W] : win_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      grant_id_q   <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      hdr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      hdr_q        <= hdr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    hdr_d        = hdr_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d    = START;
        shift_d    = win_word;
        grant_id_d = winner;
        byte_cnt_d = '0;
        hdr_d      = HDR_EN;
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : WAIT_BUSY;
      // the header byte goes out without consuming a payload byte
      WAIT_DONE: if (!tx_busy) begin
        if (hdr_q) begin
          hdr_d   = 1'b0;
          state_d = START;
        end else if (byte_cnt_q == BW'(NBYTES - 1)) begin
          state_d = ACK;
        end else begin
          shift_d    = shift_q >> 8;
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = START;
        end
      end
      ACK: begin
        state_d      = IDLE;
        last_grant_d = grant_id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start    = state_q == START;
    tx_data     = (state_q == START) ? (hdr_q ? (HDR_BASE | 8'(grant_id_q)) : shift_q[7:0]) : '0;
    grant_valid = (state_q == START) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    ack         = (state_q == ACK) ? (NREQ'(1) << grant_id_q) : '0;
    grant_id    = grant_id_q;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural UART transmitter busy model
module tb_uart_tx_arbiter;
  localparam int NREQ = 4, IDW = 2, NBYTES = 4;
`ifdef UART_TX_ARB_HEADER_EN
  localparam int FB = NBYTES + 1;
`else
  localparam int FB = NBYTES;
`endif

  logic clk = 0, reset = 1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*8*NBYTES-1:0] req_data = '0;
  logic [NREQ-1:0] ack;
  logic grant_valid;
  logic [IDW-1:0] grant_id;
  logic tx_start;
  logic [7:0] tx_data;
  logic tx_busy = 0;
  logic prev_start = 0;

  int total = 0, bad = 0;
  int cyc = 0, fall_cyc = -100, bcnt = 0, busy_len = 160, starts = 0, overlap = 0, longpulse = 0;
  int busy_tab[4] = '{160, 160, 160, 160};
  logic [7:0] sb[$];
  logic [7:0] got_b[$];
  int got_c[$], got_f[$];
  logic [IDW-1:0] got_id[$];
  logic got_v[$];
  bit tmo;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .NBYTES(NBYTES)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .grant_valid(grant_valid), .grant_id(grant_id), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // transmitter model: busy rises the cycle after an accepted start, stays high busy_len cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_start <= tx_start;
    if (tx_start && tx_busy) overlap <= overlap + 1;
    if (tx_start && prev_start) longpulse <= longpulse + 1;
    if (tx_start && !tx_busy) begin
      tx_busy <= 1'b1;
      bcnt <= busy_len;
      starts <= starts + 1;
    end else if (tx_busy) begin
      if (bcnt <= 1) begin
        tx_busy <= 1'b0;
        fall_cyc <= cyc + 1;
      end else bcnt <= bcnt - 1;
    end
  end

  task automatic push_word(input int id, input logic [31:0] w);
`ifdef UART_TX_ARB_HEADER_EN
    sb.push_back(8'hA0 | 8'(id));
`endif
    for (int j = 0; j < NBYTES; j++) sb.push_back(w[j*8 +: 8]);
  endtask

  task automatic collect(input int n);
    int c;
    got_b.delete(); got_c.delete(); got_f.delete(); got_id.delete(); got_v.delete();
    tmo = 0;
    for (int j = 0; j < n; j++) begin
      c = 0;
      while (!tx_start && c < 3000) begin @(negedge clk); c++; end
      if (!tx_start) begin tmo = 1; return; end
      got_b.push_back(tx_data); got_c.push_back(cyc); got_f.push_back(fall_cyc);
      got_id.push_back(grant_id); got_v.push_back(grant_valid);
      busy_len = busy_tab[j % 4];
      @(negedge clk);
    end
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a, output int ac, output int af, output bit to);
    int c;
    c = 0;
    while (ack === '0 && c < 3000) begin @(negedge clk); c++; end
    a = ack; ac = cyc; af = fall_cyc; to = (ack === '0);
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    total++; if (ack !== '0) begin bad++; $display("FAIL reset_ack: got %0h want 0", ack); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_grant_valid: got %0b want 0", grant_valid); end
    total++; if (grant_id !== '0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %0b want 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %0h want 0", tx_data); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int p, s0, ov0, lp0, ac, af;
    logic [NREQ-1:0] a;
    logic [7:0] e;
    bit to;
    sb.delete();
    busy_tab = '{160, 160, 160, 160};
    s0 = starts; ov0 = overlap; lp0 = longpulse;
    @(negedge clk);
    req_data[0*32 +: 32] = 32'hDEADBEEF; req = 4'b0001; p = cyc;
    push_word(0, 32'hDEADBEEF);
    collect(FB);
    total++; if (tmo || got_b.size() != FB) begin bad++; $display("FAIL single_count: got %0d want %0d", got_b.size(), FB); end
    total++; if (got_c.size() == 0 || got_c[0] !== p + 1) begin bad++; $display("FAIL single_latency: got %0d want %0d", got_c.size() ? got_c[0] : -1, p + 1); end
    total++; if (got_v.size() == 0 || got_v[0] !== 1'b1) begin bad++; $display("FAIL single_grant_valid: got 0 want 1"); end
    for (int j = 0; j < got_b.size(); j++) begin
      e = sb.pop_front();
      total++; if (got_b[j] !== e) begin bad++; $display("FAIL single_byte%0d: got %0h want %0h", j, got_b[j], e); end
    end
    for (int j = 1; j < got_c.size(); j++) begin
      total++; if (got_c[j] !== got_f[j] + 1) begin bad++; $display("FAIL single_gap%0d: got %0d want %0d", j, got_c[j], got_f[j] + 1); end
    end
    wait_ack(a, ac, af, to);
    req = '0;
    total++; if (to || a !== 4'b0001) begin bad++; $display("FAIL single_ack: got %0h want 1", a); end
    total++; if (ac !== af + 1) begin bad++; $display("FAIL single_ack_latency: got %0d want %0d", ac, af + 1); end
    @(negedge clk);
    total++; if (ack !== '0) begin bad++; $display("FAIL single_ack_width: got %0h want 0", ack); end
    total++; if (starts - s0 !== FB) begin bad++; $display("FAIL single_starts: got %0d want %0d", starts - s0, FB); end
    total++; if (overlap - ov0 !== 0 || longpulse - lp0 !== 0) begin bad++; $display("FAIL single_pulse: got %0d/%0d want 0/0", overlap - ov0, longpulse - lp0); end
  endtask

  task automatic test_contention;
    int ids[4] = '{0, 2, 3, 0};
    logic [31:0] wd[4] = '{32'h10111213, 32'h5A5B5C5D, 32'h20212223, 32'h30313233};
    logic [NREQ-1:0] a;
    logic [7:0] e;
    int ac, af;
    bit to;
    sb.delete();
    busy_tab = '{3, 3, 3, 3};
    reset = 1;
    for (int i = 0; i < NREQ; i++) req_data[i*32 +: 32] = wd[i];
    req = 4'b1101;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int w = 0; w < 4; w++) begin
      push_word(ids[w], wd[ids[w]]);
      collect(FB);
      total++; if (tmo || got_id.size() == 0 || got_id[0] !== IDW'(ids[w])) begin bad++; $display("FAIL cont_grant%0d: got %0d want %0d", w, got_id.size() ? got_id[0] : 7, ids[w]); end
      for (int j = 0; j < got_b.size(); j++) begin
        e = sb.pop_front();
        total++; if (got_b[j] !== e) begin bad++; $display("FAIL cont_w%0d_byte%0d: got %0h want %0h", w, j, got_b[j], e); end
      end
      wait_ack(a, ac, af, to);
      total++; if (to || a !== NREQ'(1 << ids[w])) begin bad++; $display("FAIL cont_ack%0d: got %0h want %0h", w, a, NREQ'(1 << ids[w])); end
      if (w > 0) req[ids[w]] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_data_change;
    logic [NREQ-1:0] a;
    logic [7:0] e;
    int ac, af;
    bit to;
    sb.delete();
    busy_tab = '{5, 5, 5, 5};
    @(negedge clk);
    req_data[1*32 +: 32] = 32'h11223344; req = 4'b0010;
    push_word(1, 32'h11223344);
    @(negedge clk);
    req_data[1*32 +: 32] = 32'h0;
    collect(FB);
    total++; if (tmo) begin bad++; $display("FAIL chg_timeout: got %0d bytes want %0d", got_b.size(), FB); end
    for (int j = 0; j < got_b.size(); j++) begin
      e = sb.pop_front();
      total++; if (got_b[j] !== e) begin bad++; $display("FAIL chg_byte%0d: got %0h want %0h", j, got_b[j], e); end
    end
    wait_ack(a, ac, af, to);
    req = '0;
    total++; if (to || a !== 4'b0010) begin bad++; $display("FAIL chg_ack: got %0h want 2", a); end
    @(negedge clk);
  endtask

  task automatic test_busy_timing;
    logic [NREQ-1:0] a;
    logic [7:0] e;
    int ac, af, s0, ov0;
    bit to;
    sb.delete();
    busy_tab = '{1, 16, 170, 1};
    s0 = starts; ov0 = overlap;
    @(negedge clk);
    req_data[2*32 +: 32] = 32'hC0FFEE42; req = 4'b0100;
    push_word(2, 32'hC0FFEE42);
    collect(FB);
    total++; if (tmo) begin bad++; $display("FAIL busy_timeout: got %0d bytes want %0d", got_b.size(), FB); end
    for (int j = 0; j < got_b.size(); j++) begin
      e = sb.pop_front();
      total++; if (got_b[j] !== e) begin bad++; $display("FAIL busy_byte%0d: got %0h want %0h", j, got_b[j], e); end
    end
    for (int j = 1; j < got_c.size(); j++) begin
      total++; if (got_c[j] !== got_f[j] + 1) begin bad++; $display("FAIL busy_gap%0d: got %0d want %0d", j, got_c[j], got_f[j] + 1); end
    end
    wait_ack(a, ac, af, to);
    req = '0;
    total++; if (to || a !== 4'b0100 || ac !== af + 1) begin bad++; $display("FAIL busy_ack: got %0h at %0d want 4 at %0d", a, ac, af + 1); end
    total++; if (starts - s0 !== FB || overlap !== ov0) begin bad++; $display("FAIL busy_starts: got %0d/%0d want %0d/0", starts - s0, overlap - ov0, FB); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [NREQ-1:0] a;
    logic [7:0] e;
    int ac, af, c;
    bit to;
    busy_tab = '{20, 20, 20, 20};
    @(negedge clk);
    req_data[2*32 +: 32] = 32'h55667788; req = 4'b0100;
    collect(FB - 1);
    repeat (5) @(negedge clk);
    reset = 1; req = '0;
    @(negedge clk);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rmid_tx_start: got %0b want 0", tx_start); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rmid_grant_valid: got %0b want 0", grant_valid); end
    total++; if (ack !== '0) begin bad++; $display("FAIL rmid_ack: got %0h want 0", ack); end
    total++; if (grant_id !== '0) begin bad++; $display("FAIL rmid_grant_id: got %0d want 0", grant_id); end
    reset = 0;
    c = 0;
    while (tx_busy && c < 3000) begin @(negedge clk); c++; end
    sb.delete();
    req_data[1*32 +: 32] = 32'h99AABBCC; req = 4'b0010;
    push_word(1, 32'h99AABBCC);
    collect(FB);
    total++; if (tmo) begin bad++; $display("FAIL rmid_timeout: got %0d bytes want %0d", got_b.size(), FB); end
    for (int j = 0; j < got_b.size(); j++) begin
      e = sb.pop_front();
      total++; if (got_b[j] !== e) begin bad++; $display("FAIL rmid_byte%0d: got %0h want %0h", j, got_b[j], e); end
    end
    wait_ack(a, ac, af, to);
    req = '0;
    total++; if (to || a !== 4'b0010) begin bad++; $display("FAIL rmid_ack2: got %0h want 2", a); end
    @(negedge clk);
  endtask

  task automatic test_header;
    logic [NREQ-1:0] a;
    logic [7:0] e;
    int ac, af;
    bit to;
    sb.delete();
    busy_tab = '{4, 4, 4, 4};
    @(negedge clk);
    req_data[3*32 +: 32] = 32'h01020304; req = 4'b1000;
    push_word(3, 32'h01020304);
    collect(FB);
    total++; if (tmo) begin bad++; $display("FAIL hdr_timeout: got %0d bytes want %0d", got_b.size(), FB); end
    for (int j = 0; j < got_b.size(); j++) begin
      e = sb.pop_front();
      total++; if (got_b[j] !== e) begin bad++; $display("FAIL hdr_byte%0d: got %0h want %0h", j, got_b[j], e); end
    end
    wait_ack(a, ac, af, to);
    req = '0;
    total++; if (to || a !== 4'b1000 || ac !== af + 1) begin bad++; $display("FAIL hdr_ack: got %0h at %0d want 8 at %0d", a, ac, af + 1); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_data_change;
    test_busy_timing;
    test_reset_mid;
    test_header;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
